// File: rtl/argmax_pkg.sv
// Shared definitions for the argmax_stream extremum finder.
// Holds the frame FSM encoding, the max/min mode constants and the fill bit
// used to build the saturated (all-ones) index at any INDEX_WIDTH.
package argmax_pkg;

  // Frame FSM: IDLE = no frame open, ACCUM = frame open, accumulating
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Selection mode as latched from find_min on the first beat
  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  // Replicated INDEX_WIDTH times to form the saturated index/count value
  localparam logic IDX_SAT_FILL = 1'b1;

endpackage

// File: rtl/argmax_stream_cmpgt.sv
// Dual-mode greater-than comparator (unsigned or two's-complement).
// Ports:
//   a_i, b_i     operands
//   is_signed_i  1 = signed compare, 0 = unsigned
//   gt_c         combinational a_i > b_i (strict)
module argmax_stream_cmpgt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             is_signed_i,
  output logic             gt_c
);

  always_comb begin
    if (is_signed_i) begin
      gt_c = $signed(a_i) > $signed(b_i);
    end else begin
      gt_c = a_i > b_i;
    end
  end

endmodule

// File: rtl/argmax_stream.sv
// Streaming extremum finder: one (value, index) result per frame of samples.
// Max/min and signed/unsigned are chosen per frame on the first beat.
// Ports:
//   clk, srst_n                    clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last  sample stream in
//   is_signed, find_min            frame mode, sampled on first beat
//   m_valid/m_ready                result handshake
//   m_data, m_index, m_overflow    extreme value, its index, index overflow
// Build option: ARGMAX_STREAM_TIE_LAST_EN makes ties select the last
// occurrence; undefined, ties keep the first occurrence.
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   srst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_last,
  input  logic                   is_signed,
  input  logic                   find_min,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic [INDEX_WIDTH-1:0] m_index,
  output logic                   m_overflow
);

  localparam logic [INDEX_WIDTH-1:0] IDX_MAX = {INDEX_WIDTH{IDX_SAT_FILL}};

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       acc_val_q, acc_val_d;
  logic [INDEX_WIDTH-1:0] acc_idx_q, acc_idx_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic                   full_q, full_d;     // a beat has taken index IDX_MAX
  logic                   ovf_q, ovf_d;
  logic                   sign_q, sign_d;
  logic                   mode_q, mode_d;
  logic                   m_valid_q, m_valid_d;
  logic [WIDTH-1:0]       m_data_q, m_data_d;
  logic [INDEX_WIDTH-1:0] m_index_q, m_index_d;
  logic                   m_overflow_q, m_overflow_d;

  logic                   accept;
  logic [WIDTH-1:0]       cmp_a, cmp_b;
  logic                   cmp_gt;
  logic                   replace;

  // Input stalls only while an unconsumed result occupies the output slot
  assign s_ready = srst_n && !(m_valid_q && !m_ready);
  assign accept  = s_valid && s_ready;

  // Swapping operands lets one strict comparator serve both max and min
  assign cmp_a = (mode_q == MODE_MIN) ? acc_val_q : s_data;
  assign cmp_b = (mode_q == MODE_MIN) ? s_data    : acc_val_q;

  argmax_stream_cmpgt #(
    .WIDTH(WIDTH)
  ) u_cmpgt (
    .a_i        (cmp_a),
    .b_i        (cmp_b),
    .is_signed_i(sign_q),
    .gt_c       (cmp_gt)
  );

`ifdef ARGMAX_STREAM_TIE_LAST_EN
  logic cmp_eq;
  assign cmp_eq  = (s_data == acc_val_q);
  assign replace = cmp_gt || cmp_eq;
`else
  assign replace = cmp_gt;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = s_last ? ST_IDLE : ST_ACCUM;
    end
  end

  // Accumulator and result next-values
  always_comb begin
    acc_val_d    = acc_val_q;
    acc_idx_d    = acc_idx_q;
    cnt_d        = cnt_q;
    full_d       = full_q;
    ovf_d        = ovf_q;
    sign_d       = sign_q;
    mode_d       = mode_q;
    m_valid_d    = m_valid_q && !m_ready;
    m_data_d     = m_data_q;
    m_index_d    = m_index_q;
    m_overflow_d = m_overflow_q;

    if (accept) begin
      if (state_q == ST_IDLE) begin
        sign_d    = is_signed;
        mode_d    = find_min;
        acc_val_d = s_data;
        acc_idx_d = '0;
        cnt_d     = INDEX_WIDTH'(1);
        full_d    = 1'b0;
        ovf_d     = 1'b0;
      end else begin
        // A beat beyond index IDX_MAX has no exact index
        if (full_q) begin
          ovf_d = 1'b1;
        end
        if (replace) begin
          acc_val_d = s_data;
          acc_idx_d = cnt_q;
        end
        if (cnt_q == IDX_MAX) begin
          full_d = 1'b1;
        end else begin
          cnt_d = cnt_q + INDEX_WIDTH'(1);
        end
      end

      // Accept implies the slot is free, so loading here never disturbs a held result
      if (s_last) begin
        m_valid_d    = 1'b1;
        m_data_d     = acc_val_d;
        m_index_d    = acc_idx_d;
        m_overflow_d = ovf_d;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      acc_val_q    <= '0;
      acc_idx_q    <= '0;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      ovf_q        <= 1'b0;
      sign_q       <= 1'b0;
      mode_q       <= MODE_MAX;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_index_q    <= '0;
      m_overflow_q <= 1'b0;
    end else begin
      acc_val_q    <= acc_val_d;
      acc_idx_q    <= acc_idx_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
      sign_q       <= sign_d;
      mode_q       <= mode_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_index_q    <= m_index_d;
      m_overflow_q <= m_overflow_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_index    = m_index_q;
  assign m_overflow = m_overflow_q;

endmodule
